// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_pkg
// Brief    : Shared op codes, FSM encoding and memory size for the LSU.
// Revision : 1.0
// ============================================================================
package load_store_unit_pkg;

  localparam int c_MEM_BYTES = 128;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic is_load(input op_e op);
    return (op < OP_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_lane.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane
// Brief    : Little-endian lane extract/extend for loads, lane merge for stores.
// Revision : 1.0
// ============================================================================
module lsu_lane
  import load_store_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  op_e         i_op,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_off)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load = i_word;
    case (i_op)
      OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load = {24'd0, w_byte};
      OP_LH:   o_load = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load = {16'd0, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    if (i_op == OP_SB) begin
      case (i_off)
        2'd0: o_merged[7:0]   = i_wdata[7:0];
        2'd1: o_merged[15:8]  = i_wdata[7:0];
        2'd2: o_merged[23:16] = i_wdata[7:0];
        2'd3: o_merged[31:24] = i_wdata[7:0];
        default: o_merged = i_word;
      endcase
    end else if (i_op == OP_SH) begin
      if (i_off[1]) o_merged[31:16] = i_wdata;
      else          o_merged[15:0]  = i_wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Memory-stage controller: sub-word loads, RMW sub-word stores.
// Revision : 1.0
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_BYTES = c_MEM_BYTES,
  parameter int ADDR_W    = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              misaligned,
  output logic              out_of_range,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_storeW,
  output logic              mem_store,
  input  logic [31:0]       mem_out
);

  state_e            r_state, w_next;
  op_e               r_op, w_req_op;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_old, r_rdata;
  logic              r_mis, r_oor;
  logic              w_mis, w_oor, w_fault, w_store, w_subword_st;
  logic [31:0]       w_word, w_load, w_merged;

  assign w_req_op = op_e'(req_op);

  always_comb begin
    w_mis = 1'b0;
    case (w_req_op)
      OP_LW, OP_SW:         w_mis = (req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: w_mis = req_addr[0];
      default:              w_mis = 1'b0;
    endcase
  end

  assign w_oor        = (req_addr >= ADDR_W'(MEM_BYTES));
  assign w_fault      = r_mis | r_oor;
  assign w_subword_st = (r_op == OP_SB) || (r_op == OP_SH);

  // The merge works on the word captured in ACCESS, never a fresh read.
  assign w_word = (r_state == ST_MERGE) ? r_old : mem_out;

  lsu_lane u_lane (
    .i_word   (w_word),
    .i_off    (r_addr[1:0]),
    .i_op     (r_op),
    .i_wdata  (r_wdata[15:0]),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_comb begin
    w_next     = r_state;
    mem_addr   = '0;
    mem_storeW = '0;
    w_store    = 1'b0;
    case (r_state)
      ST_IDLE: if (req_valid) w_next = ST_ACCESS;
      ST_ACCESS: begin
        mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
        w_next   = ST_DONE;
        if (!w_fault) begin
          if (r_op == OP_SW) begin
            w_store    = 1'b1;
            mem_storeW = r_wdata;
          end else if (w_subword_st) begin
            w_next = ST_MERGE;
          end
        end
      end
      ST_MERGE: begin
        mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
        mem_storeW = w_merged;
        w_store    = 1'b1;
        w_next     = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Reset kills a store in the same cycle, so an interrupted RMW never lands.
  assign mem_store = w_store & ~RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LW;
      r_addr  <= '0;
      r_wdata <= '0;
      r_old   <= '0;
      r_rdata <= '0;
      r_mis   <= 1'b0;
      r_oor   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && req_valid) begin
        r_op    <= w_req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_mis   <= w_mis;
        r_oor   <= w_oor;
      end
      if (r_state == ST_ACCESS) begin
        if (w_fault || !is_load(r_op)) r_rdata <= '0;
        else                           r_rdata <= w_load;
        if (!w_fault && w_subword_st)  r_old   <= mem_out;
      end
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign resp_valid   = (r_state == ST_DONE);
  assign resp_rdata   = r_rdata;
  assign misaligned   = resp_valid & r_mis;
  assign out_of_range = resp_valid & r_oor;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Scoreboard bench for load_store_unit with a word memory model.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        busy, resp_valid, misaligned, out_of_range, mem_store;
  logic [31:0] resp_rdata, mem_addr, mem_storeW, mem_out;

  load_store_unit #(.MEM_BYTES(128), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misaligned(misaligned),
    .out_of_range(out_of_range), .mem_addr(mem_addr), .mem_storeW(mem_storeW),
    .mem_store(mem_store), .mem_out(mem_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rdata;
    logic        mis, oor, chk_rdata, chk_store;
    int          acc, lat, store_off, stores;
    logic [31:0] storew;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        load_mem = 1'b1;
  int          cyc = 0, n_chk = 0, n_bad = 0;
  int          store_cnt = 0, exp_stores = 0, resp_cnt = 0, n_issued = 0;
  int          last_store_cyc = -1;
  logic [31:0] last_storew = 32'd0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)  return 32'h8899AABB;
    if (i == 31) return 32'hCAFE001F;
    return 32'h10203040 + i * 32'h01010101;
  endfunction

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (load_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
    end else if (mem_store) begin
      mem[mem_addr[6:2]] <= mem_storeW;
    end
  end
  assign mem_out = mem[mem_addr[6:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    logic [31:0] w, nw, rd;
    logic [7:0]  b;
    logic [15:0] h;
    logic        fault, st;
    e.mis = (op == 3'd0 || op == 3'd5) ? (a[1:0] != 2'b00) :
            (op == 3'd1 || op == 3'd2 || op == 3'd6) ? a[0] : 1'b0;
    e.oor = (a >= 32'd128);
    fault = e.mis | e.oor;
    st    = (op >= 3'd5);
    w     = e.oor ? 32'd0 : ref_mem[a[6:2]];
    b     = w[8*a[1:0] +: 8];
    h     = w[16*a[1] +: 16];
    case (op)
      3'd1:    rd = {{16{h[15]}}, h};
      3'd2:    rd = {16'd0, h};
      3'd3:    rd = {{24{b[7]}}, b};
      3'd4:    rd = {24'd0, b};
      default: rd = w;
    endcase
    e.rdata     = (fault || st) ? 32'd0 : rd;
    e.chk_rdata = fault || !st;
    e.chk_store = st && !fault;
    e.lat       = (st && !fault && op != 3'd5) ? 3 : 2;
    e.store_off = (op == 3'd5) ? 0 : 1;
    nw = w;
    if (op == 3'd5)      nw = wd;
    else if (op == 3'd6) nw[16*a[1] +: 16] = wd[15:0];
    else if (op == 3'd7) nw[8*a[1:0] +: 8] = wd[7:0];
    if (e.chk_store) begin
      exp_stores++;
      ref_mem[a[6:2]] = nw;
    end
    e.storew = nw;
    e.stores = exp_stores;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (mem_store) begin
      store_cnt++;
      last_store_cyc = cyc;
      last_storew    = mem_storeW;
    end
    if (resp_valid) begin
      resp_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        if (e.chk_rdata) chk("rdata", resp_rdata, e.rdata);
        chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
        chk("out_of_range", {31'd0, out_of_range}, {31'd0, e.oor});
        chk("latency", cyc - e.acc + 1, e.lat);
        chk("store_count", store_cnt, e.stores);
        if (e.chk_store) begin
          chk("store_cycle", last_store_cyc, e.acc + e.store_off);
          chk("store_word", last_storew, e.storew);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (busy && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
    exp_t e;
    wait_idle();
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    @(posedge CLK);
    #1;
    model(op, a, wd, e);
    e.acc = cyc;
    q.push_back(e);
    n_issued++;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_flags"}, {30'd0, misaligned, out_of_range}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_storeW"}, mem_storeW, 32'd0);
    chk({tag, "_mem_store"}, {31'd0, mem_store}, 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    RST = 1'b0;
    load_mem = 1'b0;

    // Sub-word loads from 0x8899AABB at 0x10
    issue(3'd3, 32'h13, 32'd0, 1'b0);
    issue(3'd4, 32'h13, 32'd0, 1'b0);
    issue(3'd1, 32'h12, 32'd0, 1'b0);
    issue(3'd2, 32'h10, 32'd0, 1'b0);
    issue(3'd0, 32'h10, 32'd0, 1'b0);

    // Alignment and range faults
    issue(3'd1, 32'h11, 32'd0, 1'b0);
    issue(3'd5, 32'h12, 32'h11111111, 1'b0);
    issue(3'd5, 32'h80, 32'hDEADBEEF, 1'b0);
    issue(3'd7, 32'h83, 32'h55, 1'b0);
    issue(3'd0, 32'h7C, 32'd0, 1'b0);
    issue(3'd0, 32'h10, 32'd0, 1'b0);

    // Reset landing in the MERGE cycle of an SH
    wait_idle();
    req_valid = 1'b1; req_op = 3'd6; req_addr = 32'h10; req_wdata = 32'h1234;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    chk("rst_merge_store", {31'd0, mem_store}, 32'd0);
    @(posedge CLK);
    #1;
    chk_all_zero("rst_merge");
    RST = 1'b0;
    chk("rst_mem_word", mem[4], 32'h8899AABB);
    issue(3'd0, 32'h10, 32'd0, 1'b0);

    // Read-modify-write stores
    issue(3'd7, 32'h11, 32'h000000CC, 1'b0);
    issue(3'd0, 32'h10, 32'd0, 1'b0);
    issue(3'd6, 32'h22, 32'hFFFF8001, 1'b0);
    issue(3'd1, 32'h22, 32'd0, 1'b0);
    issue(3'd4, 32'h23, 32'd0, 1'b0);

    // Back-to-back requests with req_valid held high
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) issue(3'd0, 32'(4 * k), 32'd0, 1'b1);
      else            issue(3'd5, 32'(4 * (k + 8)), $urandom, 1'b1);
    end
    req_valid = 1'b0;
    for (int k = 1; k < 8; k += 2) issue(3'd0, 32'(4 * (k + 8)), 32'd0, 1'b0);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    repeat (3) @(negedge CLK);
    chk("drain", q.size(), 32'd0);
    chk("resp_count", resp_cnt, n_issued);
    chk("total_stores", store_cnt, exp_stores);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
